// File: rtl/fp16_pkg.sv
// Shared binary16 constants, state encoding and operand classification for the fp16 blocks.
package fp16_pkg;

  localparam int unsigned BIAS      = 15;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_NAN  = 16'h7C01;
  localparam int unsigned DIV_STEPS = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RND  = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp16_class_t;

  // Exponent field 0 is treated as zero: subnormal inputs are flushed.
  function automatic fp16_class_t classify(input logic [15:0] x);
    fp16_class_t c;
    c.zero = (x[14:10] == 5'd0);
    c.inf  = (x[14:10] == 5'd31) && (x[9:0] == 10'd0);
    c.nan  = (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
    return c;
  endfunction

endpackage

// File: rtl/fp16_divider_if.sv
// Request/result bundle between a divider client and fp16_divider.
interface fp16_divider_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        valid;
  logic [15:0] out;

  modport master (output start, output A, output B, input busy, input valid, input out);
  modport slave  (input start, input A, input B, output busy, output valid, output out);
endinterface

// File: rtl/fp16_classify.sv
// Classifies both operands and resolves the special-case quotient combinationally.
import fp16_pkg::*;

module fp16_classify (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_special,
  output logic [15:0] o_result
);

  fp16_class_t w_cls_a;
  fp16_class_t w_cls_b;
  logic        w_sign;

  always_comb begin
    w_cls_a   = classify(i_a);
    w_cls_b   = classify(i_b);
    w_sign    = i_a[15] ^ i_b[15];
    o_special = 1'b1;
    o_result  = '0;
    // Priority matters: 0/0 and inf/inf must yield NaN before the x/0 and 0/x rules.
    if (w_cls_a.nan || w_cls_b.nan ||
        (w_cls_a.zero && w_cls_b.zero) || (w_cls_a.inf && w_cls_b.inf)) begin
      o_result = FP16_NAN;
    end else if (w_cls_b.zero || w_cls_a.inf) begin
      o_result = {w_sign, FP16_INF[14:0]};
    end else if (w_cls_a.zero || w_cls_b.inf) begin
      o_result = {w_sign, 15'h0000};
    end else begin
      o_special = 1'b0;
    end
  end

endmodule

// File: rtl/fp16_divider.sv
// Sequential binary16 divider: 13 restoring steps through one shared subtractor, then RNE rounding.
import fp16_pkg::*;

module fp16_divider (
  input  logic           CLK,
  input  logic           RESETn,
  fp16_divider_if.slave  bus
);

  state_t             r_state;
  logic               r_sign;
  logic [4:0]         r_ea;
  logic [4:0]         r_eb;
  logic [10:0]        r_mb;
  logic [11:0]        r_r;
  logic [12:0]        r_q;
  logic [3:0]         r_count;
  logic               r_valid;
  logic [15:0]        r_out;

  logic               w_special;
  logic [15:0]        w_special_res;
  logic [12:0]        w_diff;
  logic               w_ge;
  logic [9:0]         w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_adj;
  logic               w_inc;
  logic [10:0]        w_mant_rnd;
  logic signed [6:0]  w_exp;
  logic [15:0]        w_result;

  fp16_classify u_classify (
    .i_a       (bus.A),
    .i_b       (bus.B),
    .o_special (w_special),
    .o_result  (w_special_res)
  );

  assign w_diff = {1'b0, r_r} - {2'b00, r_mb};
  assign w_ge   = ~w_diff[12];

  always_comb begin
    if (r_q[12]) begin
      w_mant   = r_q[11:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (r_r != '0);
      w_adj    = 1'b0;
    end else begin
      w_mant   = r_q[10:1];
      w_guard  = r_q[0];
      w_sticky = (r_r != '0);
      w_adj    = 1'b1;
    end
    w_inc      = w_guard & (w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + 11'(w_inc);
    // Seven signed bits cover both underflow (down to -15) and overflow (up to 45).
    w_exp      = 7'(r_ea) - 7'(r_eb) + 7'(BIAS) - 7'(w_adj) + 7'(w_mant_rnd[10]);
    if (w_exp >= 7'sd31) begin
      w_result = {r_sign, FP16_INF[14:0]};
    end else if (w_exp <= 7'sd0) begin
      w_result = {r_sign, 15'h0000};
    end else begin
      w_result = {r_sign, w_exp[4:0], w_mant_rnd[9:0]};
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_mb    <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sign <= bus.A[15] ^ bus.B[15];
            r_ea   <= bus.A[14:10];
            r_eb   <= bus.B[14:10];
            if (w_special) begin
              r_out   <= w_special_res;
              r_valid <= 1'b1;
            end else begin
              r_mb    <= {1'b1, bus.B[9:0]};
              r_r     <= {2'b01, bus.A[9:0]};
              r_q     <= '0;
              r_count <= '0;
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_r     <= (w_ge ? w_diff[11:0] : r_r) << 1;
          r_q     <= {r_q[11:0], w_ge};
          r_count <= r_count + 4'd1;
          if (r_count == 4'(DIV_STEPS - 1)) begin
            r_state <= RND;
          end
        end
        RND: begin
          r_out   <= w_result;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.valid = r_valid;
  assign bus.out   = r_out;

endmodule

// File: tb/tb_fp16_divider.sv
// Self-checking bench for fp16_divider against an exact-integer-division reference model.
module tb_fp16_divider;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;

  always #5 CLK = ~CLK;

  fp16_divider_if dif ();

  fp16_divider dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (dif)
  );

  int tests = 0;
  int fails = 0;

  // Reference: exact quotient of the significands as a scaled integer, rounded to nearest even.
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, num, den, q, rem, e, sh, m;
    bit s, za, zb, ia, ib, na, nb, g, st;
    ea = int'(a[14:10]);  fa = int'(a[9:0]);
    eb = int'(b[14:10]);  fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0);  ia = (ea == 31) && (fa == 0);  na = (ea == 31) && (fa != 0);
    zb = (eb == 0);  ib = (eb == 31) && (fb == 0);  nb = (eb == 31) && (fb != 0);
    if (na || nb || (za && zb) || (ia && ib)) return {1'b1, 16'h7C01};
    if (zb || ia) return {1'b1, s, 15'h7C00};
    if (za || ib) return {1'b1, s, 15'h0000};
    num = (1024 + fa) << 14;
    den = 1024 + fb;
    q   = num / den;
    rem = num % den;
    e   = ea - eb + 15;
    if (q >= 16384) sh = 4;
    else begin sh = 3; e = e - 1; end
    m  = q >> sh;
    g  = ((q >> (sh - 1)) & 1) != 0;
    st = ((q & ((1 << (sh - 1)) - 1)) != 0) || (rem != 0);
    if (g && (st || (m % 2 == 1))) m = m + 1;
    if (m == 2048) begin m = 1024; e = e + 1; end
    if (e >= 31) return {1'b0, s, 15'h7C00};
    if (e <= 0)  return {1'b0, s, 15'h0000};
    return {1'b0, s, 5'(e), 10'(m)};
  endfunction

  // Issues one request and reports what the DUT did; lat = edges after the start edge to valid (-1 on timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat, output bit busy_bad);
    dif.A = a;  dif.B = b;  dif.start = 1'b1;
    @(posedge CLK); #1;
    dif.start = 1'b0;
    busy_bad = 1'b0;
    lat = -1;
    res = dif.out;
    if (dif.valid) begin
      lat = 0;
      busy_bad = dif.busy;
      return;
    end
    busy_bad = !dif.busy;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK); #1;
      if (dif.valid) begin
        lat = i;
        res = dif.out;
        busy_bad = busy_bad | dif.busy;
        return;
      end
      busy_bad = busy_bad | !dif.busy;
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (dif.out !== 16'h0000) begin fails++; $display("FAIL reset_out got %h want 0000", dif.out); end
    tests++; if (dif.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dif.valid); end
    tests++; if (dif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", dif.busy); end
    dif.A = 16'h3C00;  dif.B = 16'h3C00;  dif.start = 1'b1;
    @(posedge CLK); #1;
    tests++; if (dif.busy !== 1'b0) begin fails++; $display("FAIL reset_start_busy got %b want 0", dif.busy); end
    dif.start = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    tests++; if (dif.busy !== 1'b0 || dif.valid !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle got busy=%b valid=%b want 0 0", dif.busy, dif.valid);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [12] = '{16'h3C00, 16'h4600, 16'h3C00, 16'hC000, 16'h0000, 16'h7BFF,
                             16'h0400, 16'h7E00, 16'h7C00, 16'hFC00, 16'h3C00, 16'h0000};
    logic [15:0] vb [12] = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000, 16'h0000, 16'h0400,
                             16'h7BFF, 16'h3C00, 16'h7C00, 16'h3C00, 16'hFC00, 16'h4000};
    logic [15:0] vq [12] = '{16'h3C00, 16'h4200, 16'h3555, 16'hFC00, 16'h7C01, 16'h7C00,
                             16'h0000, 16'h7C01, 16'h7C01, 16'hFC00, 16'h8000, 16'h0000};
    int          vl [12] = '{14, 14, 14, 0, 0, 14, 14, 0, 0, 0, 0, 0};
    logic [15:0] res;
    int          lat;
    bit          bb;
    for (int i = 0; i < 12; i++) begin
      do_op(va[i], vb[i], res, lat, bb);
      tests++; if (res !== vq[i]) begin
        fails++; $display("FAIL directed_out[%0d] %h/%h got %h want %h", i, va[i], vb[i], res, vq[i]);
      end
      tests++; if (lat != vl[i]) begin
        fails++; $display("FAIL directed_lat[%0d] got %0d want %0d", i, lat, vl[i]);
      end
      tests++; if (bb) begin
        fails++; $display("FAIL directed_busy[%0d] got busy profile wrong want high E0..E13 only", i);
      end
      @(posedge CLK); #1;
      tests++; if (dif.valid !== 1'b0) begin
        fails++; $display("FAIL directed_pulse[%0d] got valid=%b want 0", i, dif.valid);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, res;
    logic [16:0] exp_r;
    int          lat, exp_lat;
    bit          bb;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        a = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
        b = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
      end
      exp_r   = ref_div(a, b);
      exp_lat = exp_r[16] ? 0 : 14;
      do_op(a, b, res, lat, bb);
      tests++; if (res !== exp_r[15:0] || lat != exp_lat) begin
        fails++; $display("FAIL random %h/%h got %h lat %0d want %h lat %0d", a, b, res, lat, exp_r[15:0], exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [6] = '{16'h4600, 16'h3C00, 16'h0000, 16'h4B00, 16'hC400, 16'h3C01};
    logic [15:0] bbv [6] = '{16'h4000, 16'h4200, 16'h3C00, 16'hC200, 16'h7C00, 16'h3C00};
    logic [16:0] exp_r;
    logic [15:0] res;
    int          lat;
    bit          bb;
    for (int i = 0; i < 6; i++) begin
      exp_r = ref_div(ba[i], bbv[i]);
      do_op(ba[i], bbv[i], res, lat, bb);
      tests++; if (res !== exp_r[15:0] || lat != (exp_r[16] ? 0 : 14)) begin
        fails++; $display("FAIL back_to_back[%0d] got %h lat %0d want %h", i, res, lat, exp_r[15:0]);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_start_ignored();
    int  lat;
    bit  bb;
    dif.A = 16'h4600;  dif.B = 16'h4000;  dif.start = 1'b1;
    @(posedge CLK); #1;
    dif.start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    dif.A = 16'h3C00;  dif.B = 16'h4200;  dif.start = 1'b1;
    @(posedge CLK); #1;
    dif.start = 1'b0;
    lat = -1;
    bb = 1'b0;
    for (int i = 6; i <= 30; i++) begin
      @(posedge CLK); #1;
      if (dif.valid) begin lat = i; break; end
    end
    tests++; if (lat != 14) begin fails++; $display("FAIL ignored_lat got %0d want 14", lat); end
    tests++; if (dif.out !== 16'h4200) begin fails++; $display("FAIL ignored_out got %h want 4200", dif.out); end
    @(posedge CLK); #1;
    tests++; if (dif.busy !== 1'b0 || dif.valid !== 1'b0) begin
      fails++; $display("FAIL ignored_no_restart got busy=%b valid=%b want 0 0", dif.busy, dif.valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res;
    int          lat;
    bit          bb, saw_valid;
    dif.A = 16'h3C00;  dif.B = 16'h3C00;  dif.start = 1'b1;
    @(posedge CLK); #1;
    dif.start = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    tests++; if (dif.out !== 16'h0000) begin fails++; $display("FAIL midreset_out got %h want 0000", dif.out); end
    tests++; if (dif.busy !== 1'b0 || dif.valid !== 1'b0) begin
      fails++; $display("FAIL midreset_flags got busy=%b valid=%b want 0 0", dif.busy, dif.valid);
    end
    saw_valid = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge CLK); #1;
      saw_valid = saw_valid | dif.valid | dif.busy;
    end
    tests++; if (saw_valid) begin fails++; $display("FAIL midreset_abandon got activity want none"); end
    do_op(16'h4600, 16'h4000, res, lat, bb);
    tests++; if (res !== 16'h4200 || lat != 14 || bb) begin
      fails++; $display("FAIL midreset_next got %h lat %0d busy_bad %b want 4200 lat 14", res, lat, bb);
    end
  endtask

  initial begin
    dif.start = 1'b0;
    dif.A     = '0;
    dif.B     = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp16_divider.md
FP16_DIVIDER -- requirements
Module: fp16_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed to IEEE-754 binary16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESETn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  16  dividend, binary16.
REQ-006 B  input  16  divisor, binary16.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 valid  output  1  one-cycle pulse; out holds a new result.
REQ-009 out  output  16  registered quotient; holds its value until the next result or reset.

Function
REQ-010 States SHALL be IDLE, DIV and RND; busy = (state != IDLE).
REQ-011 In IDLE with start=1 at edge E0, the block SHALL latch sign = A[15]^B[15], eA, eB, ma = {1,A[9:0]} and mb = {1,B[9:0]}.
REQ-012 A start while busy SHALL be ignored, with no effect on state or on the latched operands.
REQ-013 Exponent field 0 SHALL be treated as zero, with subnormals flushed; field 31 with mantissa 0 is inf; field 31 with a nonzero mantissa is NaN.
REQ-014 Special cases SHALL resolve at E0 and stay in IDLE, with out/valid registered at E0 (latency 1):
  - NaN operand, 0/0 or inf/inf -> 0x7C01 (sign 0).
  - x/0 or inf/finite -> {sign, 0x7C00}.
  - 0/x or finite/inf -> {sign, 0x0000}.
REQ-015 For a normal case, the block SHALL go to DIV, with remainder R = ma (12 bits) and count = 0.
REQ-016 Each DIV edge SHALL perform one restoring step:
  - q bit = (R >= mb);
  - if set, R = R - mb;
  - then R = R << 1;
  - q shifts left by one, LSB first filled.
REQ-017 DIV SHALL run exactly 13 edges (E1..E13), producing q[12:0], and go to RND at E13.
REQ-018 RND normalisation:
  - if q[12]=1: mant = q[11:2], guard = q[1], sticky = q[0] | (R != 0), adj = 0;
  - else: mant = q[10:1], guard = q[0], sticky = (R != 0), adj = 1.
REQ-019 Rounding SHALL be round-to-nearest-even: increment when guard & (sticky | mant[0]).
REQ-020 On mantissa carry-out, mant SHALL become 0 and the exponent SHALL increment by 1.
REQ-021 The biased exponent SHALL be computed as a signed 7-bit value: E = eA - eB + 15 - adj + carry.
REQ-022 Range handling:
  - E >= 31 -> out = {sign, 0x7C00};
  - E <= 0 -> out = {sign, 0x0000} (no subnormal output);
  - else out = {sign, E[4:0], mant}.
REQ-023 At E14 the block SHALL register out, pulse valid for one cycle and return to IDLE.
  - Normal latency is therefore 14 edges after the start edge.
  - A start asserted in the cycle after valid SHALL be accepted.

Reset
REQ-024 While RESETn=0, state SHALL be IDLE, with out = 0x0000, valid = 0, busy = 0, and count, R and q = 0.
REQ-025 Reset mid-operation SHALL abandon the division with no valid pulse; the first post-reset start SHALL behave as from power-up.

Structure
REQ-026 Package fp16_pkg SHALL hold BIAS=15, FP16_INF=0x7C00, FP16_NAN=0x7C01, DIV_STEPS=13 and the state encoding; the future fp16 blocks share it.
REQ-027 Operand classification and the special-case result SHALL live in one combinational sub-module, fp16_classify (zero/inf/nan flags per operand).
REQ-028 The datapath SHALL use one 12-bit subtractor, reused every DIV cycle; no combinational divider.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - A=0x3C00, B=0x3C00 -> out=0x3C00, valid at E14, busy high E0..E13.
  - A=0x4600, B=0x4000 -> 0x4200.
  - A=0x3C00, B=0x4200 -> 0x3555 (guard 0, no round).
  - A=0xC000, B=0x0000 -> 0xFC00 at E0.
  - A=0x0000, B=0x0000 -> 0x7C01 at E0.
  - A=0x7BFF, B=0x0400 -> 0x7C00; A=0x0400, B=0x7BFF -> 0x0000.
  - Start re-asserted with different operands at E5 -> ignored; result unchanged.
  - RESETn low at E7 -> out=0, no valid; next start completes normally.
